// File: rtl/stamp_pkg.sv
// Shared definitions for the stamp_window instruction window.
//   - opcode constants and the no-execute opcode list
//   - bit positions of the fields inside an 88-bit entry
//   - runnable codes driven on reg_start_flat
//   - bit indices inside the 3-bit stamp
// No ports; imported by the interface, the merge slice and the top.
package stamp_pkg;

    localparam int ENTRY_W = 88;
    localparam int OP_W    = 6;
    localparam int REG_W   = 5;
    localparam int IMM_W   = 32;
    localparam int TAKE_W  = 5;
    localparam int STAMP_W = 3;

    localparam int OP_LSB    = 82;
    localparam int RS_LSB    = 77;
    localparam int RD_LSB    = 67;
    localparam int IMM_LSB   = 35;
    localparam int TAKE_LSB  = 30;
    localparam int STAMP_LSB = 0;

    localparam logic [OP_W-1:0] OP_MOV = 6'b101010;
    localparam logic [OP_W-1:0] OP_NOT = 6'b101100;
    localparam logic [OP_W-1:0] OP_LUI = 6'b001001;

    // Stamp bits: executed, writeback token granted, written back.
    localparam int ST_EXEC  = 2;
    localparam int ST_TOKEN = 1;
    localparam int ST_DONE  = 0;

    typedef enum logic [2:0] {
        CODE_IDLE = 3'b000,
        CODE_WB   = 3'b001,
        CODE_RUN  = 3'b100
    } start_code_t;

    // Opcodes that need no execution unit; they enter the window already
    // marked executed and only wait for their writeback turn.
    function automatic logic is_no_exec(input logic [OP_W-1:0] op);
        case (op)
            OP_LUI:  return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/stamp_window_if.sv
// Bundle of all window <-> decode/unit signals.
//   master : the window side (drives ins_ready, reg_start_flat, reg_out_flat,
//            retire_valid, retire_op, count; receives ins_*, stamp_*, take_*).
//   slave  : the decode/execution-unit side, the mirror image.
// Unit u, slot i: stamp value at stamp_flat[24u+3i +: 3], strobe at
// stamp_in[8u+i], take value at take_flat[40u+5i +: 5], strobe at take_in[8u+i].
interface stamp_window_if
    import stamp_pkg::*;
#(
    parameter int NUM_UNITS = 2
);
    logic [ENTRY_W-1:0]      ins_in;
    logic                    ins_valid;
    logic                    ins_ready;
    logic [23:0]             reg_start_flat;
    logic [8*ENTRY_W-1:0]    reg_out_flat;
    logic [24*NUM_UNITS-1:0] stamp_flat;
    logic [8*NUM_UNITS-1:0]  stamp_in;
    logic [40*NUM_UNITS-1:0] take_flat;
    logic [8*NUM_UNITS-1:0]  take_in;
    logic                    retire_valid;
    logic [OP_W-1:0]         retire_op;
    logic [3:0]              count;

    modport master (
        input  ins_in, ins_valid, stamp_flat, stamp_in, take_flat, take_in,
        output ins_ready, reg_start_flat, reg_out_flat, retire_valid, retire_op, count
    );

    modport slave (
        output ins_in, ins_valid, stamp_flat, stamp_in, take_flat, take_in,
        input  ins_ready, reg_start_flat, reg_out_flat, retire_valid, retire_op, count
    );
endinterface

// File: rtl/stamp_merge.sv
// Per-slot merge of the unit write buses.
//   slot_valid            : slot holds an entry; writes to empty slots are ignored
//   stamp_old / take_old  : registered stamp and take field of the slot
//   stamp_val / stamp_strb: per-unit stamp values (3 bits each) and strobes
//   take_val / take_strb  : per-unit take values (5 bits each) and strobes
//   stamp_new / take_new  : merged values
// Stamps accumulate (OR); the take field goes to the lowest-index unit strobing.
module stamp_merge #(
    parameter int NUM_UNITS = 2
) (
    input  logic                   slot_valid,
    input  logic [2:0]             stamp_old,
    input  logic [4:0]             take_old,
    input  logic [3*NUM_UNITS-1:0] stamp_val,
    input  logic [NUM_UNITS-1:0]   stamp_strb,
    input  logic [5*NUM_UNITS-1:0] take_val,
    input  logic [NUM_UNITS-1:0]   take_strb,
    output logic [2:0]             stamp_new,
    output logic [4:0]             take_new
);
    always_comb begin
        stamp_new = stamp_old;
        take_new  = take_old;
        if (slot_valid) begin
            for (int u = 0; u < NUM_UNITS; u++) begin
                if (stamp_strb[u]) stamp_new = stamp_new | stamp_val[3*u +: 3];
            end
            // Walk downwards so the lowest-index unit is applied last and wins.
            for (int u = NUM_UNITS - 1; u >= 0; u--) begin
                if (take_strb[u]) take_new = take_val[5*u +: 5];
            end
        end
    end
endmodule

// File: rtl/stamp_window.sv
// stamp_window: 8-slot in-order instruction window feeding execution units.
// Slot 7 is oldest; valid slots are 7 down to 8-count. Units stamp/take slots,
// the window grants in-order writeback tokens and retires slot 7 at stamp 111.
// Ports:
//   clk   : clock
//   reset : asynchronous, active-low reset
//   bus   : stamp_window_if.master (decode insert, unit buses, window outputs)
// Optional feature macro: WINDOW_RAW_CHECK_EN -- when defined, runnable code
// 100 is withheld while an older unfinished entry writes this entry's rs.
module stamp_window
    import stamp_pkg::*;
#(
    parameter int NUM_UNITS = 2,
    parameter int DEPTH     = 8
) (
    input  logic           clk,
    input  logic           reset,
    stamp_window_if.master bus
);
    logic [ENTRY_W-1:0] entry_q [DEPTH];
    logic [ENTRY_W-1:0] upd     [DEPTH];
    logic [ENTRY_W-1:0] nxt     [DEPTH];
    logic [2:0]         merged_stamp [DEPTH];
    logic [4:0]         merged_take  [DEPTH];
    logic [2:0]         tok_stamp    [DEPTH];
    logic [DEPTH-1:0]   valid;
    logic [DEPTH-1:0]   run_ok;
    logic [3:0]         count_q, count_d;
    logic               retire, accept, older_done;
    logic [2:0]         ins_pos;
    logic [ENTRY_W-1:0] new_entry;
    logic               retire_valid_q;
    logic [OP_W-1:0]    retire_op_q;

    // Occupancy is contiguous from slot 7 down, so validity follows from count.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) valid[i] = (i + int'(count_q)) >= DEPTH;
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        logic [3*NUM_UNITS-1:0] sv;
        logic [NUM_UNITS-1:0]   ss;
        logic [5*NUM_UNITS-1:0] tv;
        logic [NUM_UNITS-1:0]   ts;
        for (genvar u = 0; u < NUM_UNITS; u++) begin : g_unit
            assign sv[3*u +: 3] = bus.stamp_flat[24*u + 3*i +: 3];
            assign ss[u]        = bus.stamp_in[8*u + i];
            assign tv[5*u +: 5] = bus.take_flat[40*u + 5*i +: 5];
            assign ts[u]        = bus.take_in[8*u + i];
        end
        stamp_merge #(.NUM_UNITS(NUM_UNITS)) u_merge (
            .slot_valid (valid[i]),
            .stamp_old  (entry_q[i][STAMP_LSB +: STAMP_W]),
            .take_old   (entry_q[i][TAKE_LSB +: TAKE_W]),
            .stamp_val  (sv),
            .stamp_strb (ss),
            .take_val   (tv),
            .take_strb  (ts),
            .stamp_new  (merged_stamp[i]),
            .take_new   (merged_take[i])
        );
        assign bus.reg_out_flat[ENTRY_W*i +: ENTRY_W] = entry_q[i];
    end

    // Token grant walks from the oldest slot, using this edge's merged stamps,
    // so a slot finishing writeback hands the token on within the same edge.
    always_comb begin
        older_done = 1'b1;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            tok_stamp[i] = merged_stamp[i];
            if (valid[i] && merged_stamp[i][ST_EXEC] && older_done)
                tok_stamp[i][ST_TOKEN] = 1'b1;
            older_done = older_done & (~valid[i] | merged_stamp[i][ST_DONE]);
            upd[i] = entry_q[i];
            upd[i][TAKE_LSB +: TAKE_W]   = merged_take[i];
            upd[i][STAMP_LSB +: STAMP_W] = tok_stamp[i];
        end
    end

    assign retire        = valid[DEPTH-1] && (tok_stamp[DEPTH-1] == 3'b111);
    assign bus.ins_ready = count_q < 4'(DEPTH);
    assign accept        = bus.ins_valid && bus.ins_ready;
    // After a retire shift the first free slot moves up by one.
    assign ins_pos       = 3'(DEPTH - 1 - int'(count_q) + (retire ? 1 : 0));

    always_comb begin
        new_entry = bus.ins_in;
        new_entry[TAKE_LSB +: TAKE_W]   = '0;
        new_entry[STAMP_LSB +: STAMP_W] = is_no_exec(bus.ins_in[OP_LSB +: OP_W]) ? 3'b100 : 3'b000;
    end

    always_comb begin
        if (retire) begin
            for (int i = 1; i < DEPTH; i++) nxt[i] = upd[i-1];
            nxt[0] = '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) nxt[i] = upd[i];
        end
        if (accept) nxt[ins_pos] = new_entry;
    end

    assign count_d = count_q + {3'b000, accept} - {3'b000, retire};

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            run_ok[i] = 1'b1;
`ifdef WINDOW_RAW_CHECK_EN
            for (int j = i + 1; j < DEPTH; j++) begin
                if (valid[j] && !entry_q[j][STAMP_LSB + ST_DONE] &&
                    (entry_q[j][RD_LSB +: REG_W] == entry_q[i][RS_LSB +: REG_W]))
                    run_ok[i] = 1'b0;
            end
`endif
        end
    end

    // Runnable codes look at registered state only.
    always_comb begin
        bus.reg_start_flat = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i]) begin
                if (entry_q[i][STAMP_LSB +: STAMP_W] == 3'b000 && run_ok[i])
                    bus.reg_start_flat[3*i +: 3] = CODE_RUN;
                else if (entry_q[i][STAMP_LSB +: STAMP_W] == 3'b110)
                    bus.reg_start_flat[3*i +: 3] = CODE_WB;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
            count_q        <= '0;
            retire_valid_q <= 1'b0;
            retire_op_q    <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) entry_q[i] <= nxt[i];
            count_q        <= count_d;
            retire_valid_q <= retire;
            retire_op_q    <= retire ? entry_q[DEPTH-1][OP_LSB +: OP_W] : '0;
        end
    end

    assign bus.retire_valid = retire_valid_q;
    assign bus.retire_op    = retire_op_q;
    assign bus.count        = count_q;
endmodule

// File: tb/tb_stamp_window.sv
// Directed bench for stamp_window: a per-cycle vector table for the basic
// stamp/take/retire flow on slot 7, then hand-written multi-cycle sequences
// for fill/full-with-retire, mid-operation reset, insert during retire,
// in-order token hand-off and the optional read-after-write hold.
module tb_stamp_window;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    stamp_window_if #(.NUM_UNITS(2)) bus ();

    stamp_window #(.NUM_UNITS(2), .DEPTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    localparam logic [5:0] MOV = 6'b101010;
    localparam logic [5:0] NOTOP = 6'b101100;
    localparam logic [5:0] LUI = 6'b001001;

    typedef struct packed {
        logic       iv;
        logic [5:0] op;
        logic [4:0] rs;
        logic [4:0] rd;
        logic       s0;
        logic [2:0] s0v;
        logic       t0;
        logic [4:0] t0v;
        logic       s1;
        logic [2:0] s1v;
        logic       t1;
        logic [4:0] t1v;
        logic [3:0] e_cnt;
        logic [2:0] e_code;
        logic [2:0] e_stamp;
        logic [4:0] e_take;
        logic       e_rv;
        logic [5:0] e_rop;
    } vec_t;

    vec_t vecs [11];

    function automatic logic [87:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rd, input logic [31:0] imm);
        logic [87:0] e;
        e = '0;
        e[87:82] = op;
        e[81:77] = rs;
        e[71:67] = rd;
        e[66:35] = imm;
        return e;
    endfunction

    function automatic logic [87:0] slot_e(input int i);
        return bus.reg_out_flat[88*i +: 88];
    endfunction

    function automatic logic [2:0] code(input int i);
        return bus.reg_start_flat[3*i +: 3];
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clr_inputs();
        bus.ins_valid  = 1'b0;
        bus.ins_in     = '0;
        bus.stamp_flat = '0;
        bus.stamp_in   = '0;
        bus.take_flat  = '0;
        bus.take_in    = '0;
    endtask

    task automatic set_stamp(input int u, input int slot, input logic [2:0] v);
        bus.stamp_flat[24*u + 3*slot +: 3] = v;
        bus.stamp_in[8*u + slot] = 1'b1;
    endtask

    task automatic set_take(input int u, input int slot, input logic [4:0] v);
        bus.take_flat[40*u + 5*slot +: 5] = v;
        bus.take_in[8*u + slot] = 1'b1;
    endtask

    // Inserted entries carry junk in take/stamp to show those fields are forced.
    task automatic drive_ins(input logic [87:0] e);
        bus.ins_valid = 1'b1;
        bus.ins_in    = e | {53'd0, 5'h1f, 27'd0, 3'b111};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        clr_inputs();
        reset = 1'b0;
        #1;
        check("rst_count", bus.count, 4'd0);
        check("rst_regout", {127'd0, |bus.reg_out_flat}, 128'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        //          iv op     rs rd   s0 s0v    t0 t0v  s1 s1v    t1 t1v  cnt code    stamp   take rv rop
        vecs[0]  = '{1'b1, MOV,   5'd3, 5'd5, 1'b0, 3'b000, 1'b0, 5'd0, 1'b0, 3'b000, 1'b0, 5'd0,  4'd1, 3'b100, 3'b000, 5'd0,  1'b0, 6'd0};
        vecs[1]  = '{1'b0, 6'd0,  5'd0, 5'd0, 1'b1, 3'b100, 1'b1, 5'd9, 1'b0, 3'b000, 1'b1, 5'd17, 4'd1, 3'b001, 3'b110, 5'd9,  1'b0, 6'd0};
        vecs[2]  = '{1'b0, 6'd0,  5'd0, 5'd0, 1'b0, 3'b000, 1'b0, 5'd0, 1'b1, 3'b111, 1'b0, 5'd0,  4'd0, 3'b000, 3'b000, 5'd0,  1'b1, MOV};
        vecs[3]  = '{1'b0, 6'd0,  5'd0, 5'd0, 1'b0, 3'b000, 1'b0, 5'd0, 1'b0, 3'b000, 1'b0, 5'd0,  4'd0, 3'b000, 3'b000, 5'd0,  1'b0, 6'd0};
        vecs[4]  = '{1'b1, LUI,   5'd0, 5'd7, 1'b0, 3'b000, 1'b0, 5'd0, 1'b0, 3'b000, 1'b0, 5'd0,  4'd1, 3'b000, 3'b100, 5'd0,  1'b0, 6'd0};
        vecs[5]  = '{1'b0, 6'd0,  5'd0, 5'd0, 1'b0, 3'b000, 1'b0, 5'd0, 1'b0, 3'b000, 1'b0, 5'd0,  4'd1, 3'b001, 3'b110, 5'd0,  1'b0, 6'd0};
        vecs[6]  = '{1'b0, 6'd0,  5'd0, 5'd0, 1'b1, 3'b001, 1'b0, 5'd0, 1'b0, 3'b000, 1'b0, 5'd0,  4'd0, 3'b000, 3'b000, 5'd0,  1'b1, LUI};
        vecs[7]  = '{1'b0, 6'd0,  5'd0, 5'd0, 1'b1, 3'b111, 1'b1, 5'd3, 1'b0, 3'b000, 1'b0, 5'd0,  4'd0, 3'b000, 3'b000, 5'd0,  1'b0, 6'd0};
        vecs[8]  = '{1'b1, NOTOP, 5'd1, 5'd2, 1'b0, 3'b000, 1'b0, 5'd0, 1'b0, 3'b000, 1'b0, 5'd0,  4'd1, 3'b100, 3'b000, 5'd0,  1'b0, 6'd0};
        vecs[9]  = '{1'b0, 6'd0,  5'd0, 5'd0, 1'b1, 3'b010, 1'b0, 5'd0, 1'b0, 3'b000, 1'b1, 5'd21, 4'd1, 3'b000, 3'b010, 5'd21, 1'b0, 6'd0};
        vecs[10] = '{1'b0, 6'd0,  5'd0, 5'd0, 1'b1, 3'b100, 1'b0, 5'd0, 1'b1, 3'b001, 1'b0, 5'd0,  4'd0, 3'b000, 3'b000, 5'd0,  1'b1, NOTOP};

        clr_inputs();
        repeat (2) @(posedge clk);
        #1;
        check("reset_count", bus.count, 4'd0);
        check("reset_ready", bus.ins_ready, 1'b1);
        check("reset_rv", bus.retire_valid, 1'b0);
        check("reset_rop", bus.retire_op, 6'd0);
        check("reset_start", bus.reg_start_flat, 24'd0);
        check("reset_regout", {127'd0, |bus.reg_out_flat}, 128'd0);
        reset = 1'b1;
        step();

        // ---- vector table: everything targets slot 7 ----
        for (int k = 0; k < 11; k++) begin
            clr_inputs();
            if (vecs[k].iv) drive_ins(mk(vecs[k].op, vecs[k].rs, vecs[k].rd, 32'h0));
            if (vecs[k].s0) set_stamp(0, 7, vecs[k].s0v);
            if (vecs[k].t0) set_take(0, 7, vecs[k].t0v);
            if (vecs[k].s1) set_stamp(1, 7, vecs[k].s1v);
            if (vecs[k].t1) set_take(1, 7, vecs[k].t1v);
            step();
            check($sformatf("v%0d_count", k), bus.count, vecs[k].e_cnt);
            check($sformatf("v%0d_code7", k), code(7), vecs[k].e_code);
            check($sformatf("v%0d_stamp7", k), slot_e(7)[2:0], vecs[k].e_stamp);
            check($sformatf("v%0d_take7", k), slot_e(7)[34:30], vecs[k].e_take);
            check($sformatf("v%0d_rv", k), bus.retire_valid, vecs[k].e_rv);
            check($sformatf("v%0d_rop", k), bus.retire_op, vecs[k].e_rop);
            if (vecs[k].iv)
                check($sformatf("v%0d_opfield", k), slot_e(7)[87:82], vecs[k].op);
        end
        clr_inputs();

        // ---- fill 8 entries, then retire while the window is full ----
        for (int k = 0; k < 8; k++) begin
            clr_inputs();
            drive_ins(mk(MOV, 5'(k), 5'(k + 8), 32'(k)));
            step();
        end
        clr_inputs();
        check("fill_count", bus.count, 4'd8);
        check("fill_ready", bus.ins_ready, 1'b0);
        check("fill_slot7", slot_e(7), mk(MOV, 5'd0, 5'd8, 32'd0));
        check("fill_slot0", slot_e(0), mk(MOV, 5'd7, 5'd15, 32'd7));
        check("fill_code0", code(0), 3'b100);

        drive_ins(mk(MOV, 5'd3, 5'd20, 32'd8));
        set_stamp(0, 7, 3'b111);
        step();
        check("full_ret_rv", bus.retire_valid, 1'b1);
        check("full_ret_rop", bus.retire_op, MOV);
        check("full_ret_count", bus.count, 4'd7);
        check("full_ret_ready", bus.ins_ready, 1'b1);
        check("full_ret_slot7", slot_e(7), mk(MOV, 5'd1, 5'd9, 32'd1));
        check("full_ret_slot1", slot_e(1), mk(MOV, 5'd7, 5'd15, 32'd7));
        check("full_ret_slot0", slot_e(0), 88'd0);
        bus.stamp_in = '0;
        step();
        clr_inputs();
        check("full_acc_count", bus.count, 4'd8);
        check("full_acc_slot0", slot_e(0), mk(MOV, 5'd3, 5'd20, 32'd8));
        check("full_acc_rv", bus.retire_valid, 1'b0);
        check("full_acc_ready", bus.ins_ready, 1'b0);

        // ---- mid-operation reset discards everything ----
        pulse_reset();
        step();
        check("post_rst_count", bus.count, 4'd0);

        // ---- insert during a retire lands one slot higher ----
        drive_ins(mk(MOV, 5'd1, 5'd11, 32'd1));
        step();
        drive_ins(mk(MOV, 5'd2, 5'd12, 32'd2));
        step();
        clr_inputs();
        drive_ins(mk(MOV, 5'd3, 5'd13, 32'd3));
        set_stamp(1, 7, 3'b111);
        step();
        clr_inputs();
        check("insret_count", bus.count, 4'd2);
        check("insret_rv", bus.retire_valid, 1'b1);
        check("insret_slot7", slot_e(7), mk(MOV, 5'd2, 5'd12, 32'd2));
        check("insret_slot6", slot_e(6), mk(MOV, 5'd3, 5'd13, 32'd3));

        // ---- writeback token waits for older written-back ----
        set_stamp(0, 6, 3'b100);
        step();
        clr_inputs();
        check("tok1_stamp6", slot_e(6)[2:0], 3'b100);
        check("tok1_code6", code(6), 3'b000);
        check("tok1_code7", code(7), 3'b100);
        set_stamp(1, 7, 3'b100);
        step();
        clr_inputs();
        check("tok2_stamp7", slot_e(7)[2:0], 3'b110);
        check("tok2_stamp6", slot_e(6)[2:0], 3'b100);
        set_stamp(0, 7, 3'b001);
        step();
        clr_inputs();
        check("tok3_rv", bus.retire_valid, 1'b1);
        check("tok3_count", bus.count, 4'd1);
        check("tok3_stamp7", slot_e(7)[2:0], 3'b110);
        check("tok3_code7", code(7), 3'b001);

        // ---- read-after-write hold on runnable code ----
        pulse_reset();
        drive_ins(mk(MOV, 5'd0, 5'd4, 32'd0));
        step();
        drive_ins(mk(MOV, 5'd4, 5'd1, 32'd0));
        step();
        clr_inputs();
        check("raw_code7", code(7), 3'b100);
`ifdef WINDOW_RAW_CHECK_EN
        check("raw_code6_hold", code(6), 3'b000);
`else
        check("raw_code6_hold", code(6), 3'b100);
`endif
        set_stamp(0, 7, 3'b001);
        step();
        clr_inputs();
        check("raw_code6_free", code(6), 3'b100);
        check("raw_code7_after", code(7), 3'b000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/stamp_window.md
Name: stamp_window

Overview:
- 8-slot in-order instruction window; the supplier end of the start/stamp/take protocol that execution units consume.
- Holds 88-bit instruction entries plus 3-bit stamps and drives the flat runnable-code bus and the flat entry bus to all units.
- Absorbs stamp and take writes from the units, grants in-order writeback, and retires completed entries.
- Sits between fetch/decode and the execution units.

Parameters:
- NUM_UNITS, 2, number of execution units driving stamp/take buses.
- DEPTH, 8, slot count; fixed at 8 because unit buses are 8 slots wide.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- ins_in  in  88  new entry from decode.
- ins_valid  in  1  ins_in valid.
- ins_ready  out  1  window can accept an entry this cycle.
- reg_start_flat  out  24  per-slot runnable code, 3 bits per slot, slot i at [3i+2:3i].
- reg_out_flat  out  704  per-slot entry, slot i at [88i+87:88i].
- stamp_flat  in  24*NUM_UNITS  per-unit per-slot stamp values.
- stamp_in  in  8*NUM_UNITS  per-unit per-slot stamp strobes.
- take_flat  in  40*NUM_UNITS  per-unit per-slot 5-bit take values.
- take_in  in  8*NUM_UNITS  per-unit per-slot take strobes.
- retire_valid  out  1  one-cycle pulse: slot 7 retired.
- retire_op  out  6  opcode of the retired entry.
- count  out  4  occupied slots, 0..8.

Behaviour:
- Entry fields: [87:82] opcode, [81:77] rs, [71:67] rd, [66:35] imm, [34:30] take, [2:0] stamp.
- Stamp bits: bit2 = executed, bit1 = writeback token, bit0 = written back.
- Age: slot 7 is oldest; valid slots are always contiguous, slots 7 down to 8-count.
- Reset (async, active-low): all valid bits cleared, entries zeroed.
  - count=0, ins_ready=1, retire_valid=0, retire_op=0.
  - reg_start_flat=0, reg_out_flat=0.
  - Asserting reset mid-operation discards all entries.
- reg_start is combinational from registered state only, never from same-cycle unit inputs:
  - 3'b100 when slot valid and stamp==000.
  - 3'b001 when slot valid and stamp==110.
  - 3'b000 otherwise.
- Writeback token: on each edge, bit1 is set for a valid slot whose bit2=1 and whose older valid slots all have bit0=1.
- Stamp merge per slot, per edge:
  - new stamp = old stamp OR (OR of stamp values over units whose strobe is set).
  - Stamps only ever set bits.
- Take merge: lowest-index unit with its strobe set writes [34:30]; other units' take writes that cycle are dropped.
- Stamp/take strobes addressed to invalid slots are ignored.
- Retire: slot 7 valid and stamp==111 → retire_valid=1 next cycle, retire_op=opcode.
  - All slots shift up one (slot i-1 → slot i); count decrements.
  - At most one retire per cycle.
- Ordering within one edge: merge (pre-shift indices), token update, retire shift, then insert.
- Insert: ins_ready = (count<8), from registered count; a same-cycle retire does not raise it.
  - On ins_valid&&ins_ready, the entry is written at slot 7-count, or 8-count if a retire happens that edge.
  - Take field is forced to 0.
  - Stamp is forced to 000, except opcodes in the no-execute list (LUI 6'b001001), which get 100.
- count update: +1 on insert, -1 on retire, unchanged when both or neither occur.
- A full window with simultaneous retire accepts nothing; the entry is accepted next cycle.

Optional Feature:
- Macro WINDOW_RAW_CHECK_EN.
- Defined: code 100 additionally requires that no older valid slot with bit0=0 has rd equal to this slot's rs.
- Undefined: no hazard check; 100 depends on stamp only.

Decomposition:
- Package stamp_pkg holds:
  - opcode constants (MOV 101010, NOT 101100, LUI 001001);
  - no-execute opcode list;
  - field bit positions;
  - reg_start codes 100/001/000;
  - stamp bit indices.
- One sub-module, stamp_merge: per-slot OR of NUM_UNITS stamp updates plus lowest-index take select; instantiated 8 times.

Test Plan:
- Reset then insert MOV (rs=3, rd=5) → slot 7 valid, count=1, slot 7 code 100.
- Unit0 stamp_in[7]=1, stamp=100, take_in[7]=1, take=9 → next cycle slot 7 take=9, stamp 110, code 001.
- Unit1 then stamps 111 on slot 7 → retire_valid=1, retire_op=101010, count=0.
- Insert LUI → stamp 100 on insert; token set next edge, code 001; no 100 phase.
- Fill 8 entries: ins_ready=0. Retire slot 7 while ins_valid is held → no accept that edge, entries shift up, accepted next cycle at slot 0, count returns to 8.
- With WINDOW_RAW_CHECK_EN: slot 7 MOV rd=4 unfinished, slot 6 MOV rs=4 → slot 6 code 000 until slot 7 bit0=1, then 100; without the macro → 100 immediately.
